conv_accum_requant: RTL

//   Accumulates cfg_taps signed partial sums per output (Q16.16 MAC products) on top of a Q8.8 bias.

---
 rtl/conv_accum_requant_if.sv | 24 ++
 rtl/conv_accum_requant.sv | 66 ++++++
 2 files changed

// File: rtl/conv_accum_requant_if.sv
// conv_accum_requant_if: partial-sum input stream, per-output config and Q8.8 result stream
interface conv_accum_requant_if #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int TAPS_WIDTH = 8
);
    logic [TAPS_WIDTH-1:0]       cfg_taps;
    logic signed [OUT_WIDTH-1:0] bias_in;
    logic signed [IN_WIDTH-1:0]  psum_in;
    logic                        psum_valid;
    logic                        psum_ready;
    logic signed [OUT_WIDTH-1:0] data_out;
    logic                        valid_out;
    logic                        sat_out;
    logic                        ready_in;
    modport master (
        output cfg_taps, bias_in, psum_in, psum_valid, ready_in,
        input  psum_ready, data_out, valid_out, sat_out
    );
    modport slave (
        input  cfg_taps, bias_in, psum_in, psum_valid, ready_in,
        output psum_ready, data_out, valid_out, sat_out
    );
endinterface

// File: rtl/conv_accum_requant.sv
// conv_accum_requant: accumulates cfg_taps Q16.16 partial sums onto a Q8.8 bias, then rounds and saturates to Q8.8
module conv_accum_requant #(
    parameter int IN_WIDTH   = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 8,
    parameter int TAPS_WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    conv_accum_requant_if.slave io
);
    typedef enum logic {FIRST, RUN} state_t;
    localparam logic signed [ACC_WIDTH-1:0] RND     = ACC_WIDTH'(1) << (FRAC_SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = (ACC_WIDTH'(1) << (OUT_WIDTH - 1)) - ACC_WIDTH'(1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = -(ACC_WIDTH'(1) << (OUT_WIDTH - 1));
    state_t                      state_q, state_d;
    logic [TAPS_WIDTH-1:0]       taps_q, taps_d, cnt_q, cnt_d, taps_eff;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_sum, rnd_sum, rnd;
    logic signed [OUT_WIDTH-1:0] data_q, data_d;
    logic                        valid_q, valid_d, sat_q, sat_d;
    logic                        final_pending, ready, beat, last;
    always_comb begin
        taps_eff      = io.cfg_taps == '0 ? TAPS_WIDTH'(1) : io.cfg_taps;
        final_pending = state_q == FIRST ? taps_eff == TAPS_WIDTH'(1) : cnt_q == taps_q - TAPS_WIDTH'(1);
        ready         = !rst && !(final_pending && valid_q && !io.ready_in);
        beat          = io.psum_valid && ready;
        last          = beat && final_pending;
        acc_sum       = (state_q == FIRST ? ACC_WIDTH'(io.bias_in) <<< FRAC_SHIFT : acc_q)
                      + {{(ACC_WIDTH-IN_WIDTH){io.psum_in[IN_WIDTH-1]}}, io.psum_in};
        rnd_sum       = acc_sum + RND;
        rnd           = rnd_sum >>> FRAC_SHIFT;
        state_d       = beat ? (last ? FIRST : RUN) : state_q;
        taps_d        = beat && state_q == FIRST ? taps_eff : taps_q;
        cnt_d         = beat ? (state_q == FIRST ? TAPS_WIDTH'(1) : cnt_q + TAPS_WIDTH'(1)) : cnt_q;
        acc_d         = beat ? acc_sum : acc_q;
        valid_d       = last || (valid_q && !io.ready_in);
        data_d        = !last ? data_q :
                        rnd > OUT_MAX ? OUT_MAX[OUT_WIDTH-1:0] :
                        rnd < OUT_MIN ? OUT_MIN[OUT_WIDTH-1:0] : rnd[OUT_WIDTH-1:0];
        sat_d         = last ? (rnd > OUT_MAX || rnd < OUT_MIN) : sat_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FIRST;
            taps_q  <= TAPS_WIDTH'(1);
            cnt_q   <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            taps_q  <= taps_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end
    assign io.psum_ready = ready;
    assign io.data_out   = data_q;
    assign io.valid_out  = valid_q;
    assign io.sat_out    = sat_q;
endmodule
